// File: rtl/pc_unit.sv
// Program-counter generator: sequential fetch address, redirects, stalls and an accepted-fetch counter.
// Optional build macro PC_MISALIGN_TRAP_EN turns misaligned redirects into a one-cycle trap to TRAP_VEC.
module pc_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0] TRAP_VEC = PC_WIDTH'(4)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_stall,
    input  logic                i_fetch_ready,
    input  logic                i_redirect,
    input  logic [PC_WIDTH-1:0] i_redirect_target,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [PC_WIDTH-1:0] o_pc_plus4,
    output logic                o_pc_valid,
    output logic [31:0]         o_fetch_count,
    output logic                o_misalign,
    output logic [PC_WIDTH-1:0] o_bad_addr
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD, S_TRAP} state_t;

    state_t              r_state, w_next_state;
    logic [PC_WIDTH-1:0] r_pc, w_next_pc;
    logic                r_pc_valid;
    logic [31:0]         r_fetch_count;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_target_aligned;
    logic                w_fetch_accept;

    assign w_pc_plus4       = r_pc + PC_WIDTH'(4);
    assign w_target_aligned = i_redirect_target & ~PC_WIDTH'(3);
    assign w_fetch_accept   = r_pc_valid & i_fetch_ready;

`ifdef PC_MISALIGN_TRAP_EN
    logic                w_trap_enter;
    logic                r_misalign;
    logic [PC_WIDTH-1:0] r_bad_addr;
    logic                w_target_misaligned;

    assign w_target_misaligned = |i_redirect_target[1:0];
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
`ifdef PC_MISALIGN_TRAP_EN
        w_trap_enter = 1'b0;
`endif
        case (r_state)
            S_BOOT: w_next_state = S_RUN;
            // RUN and HOLD share one rule set; HOLD only records that pc did not advance.
            S_RUN, S_HOLD: begin
                if (i_redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (w_target_misaligned) begin
                        w_next_state = S_TRAP;
                        w_next_pc    = TRAP_VEC;
                        w_trap_enter = 1'b1;
                    end else begin
                        w_next_state = S_RUN;
                        w_next_pc    = w_target_aligned;
                    end
`else
                    w_next_state = S_RUN;
                    w_next_pc    = w_target_aligned;
`endif
                end else if (i_stall || !i_fetch_ready) begin
                    w_next_state = S_HOLD;
                end else begin
                    w_next_state = S_RUN;
                    w_next_pc    = w_pc_plus4;
                end
            end
`ifdef PC_MISALIGN_TRAP_EN
            S_TRAP: begin
                w_next_state = S_RUN;
                w_next_pc    = w_pc_plus4;
            end
`endif
            default: w_next_state = S_BOOT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_pc_valid    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_pc_valid <= (w_next_state == S_RUN) || (w_next_state == S_HOLD);
            if (w_fetch_accept && (r_fetch_count != 32'hFFFF_FFFF))
                r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_misalign <= 1'b0;
            r_bad_addr <= '0;
        end else begin
            r_misalign <= w_trap_enter;
            if (w_trap_enter)
                r_bad_addr <= i_redirect_target;
        end
    end

    assign o_misalign = r_misalign;
    assign o_bad_addr = r_bad_addr;
`else
    assign o_misalign = 1'b0;
    assign o_bad_addr = '0;
`endif

    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_pc_valid    = r_pc_valid;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table for the reset/stall/redirect/wrap corners,
// then randomized traffic checked against a flat behavioural model of the fetch rules.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst, stall, fetch_ready, redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc, pc_plus4, fetch_count, bad_addr;
    logic        pc_valid, misalign;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .TRAP_VEC(32'h4)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_stall           (stall),
        .i_fetch_ready     (fetch_ready),
        .i_redirect        (redirect),
        .i_redirect_target (redirect_target),
        .o_pc              (pc),
        .o_pc_plus4        (pc_plus4),
        .o_pc_valid        (pc_valid),
        .o_fetch_count     (fetch_count),
        .o_misalign        (misalign),
        .o_bad_addr        (bad_addr)
    );

    typedef struct {
        logic        rst, stall, rdy, redir;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_cnt;
        logic        e_mis;
        logic [31:0] e_bad;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic f, input logic d,
                       input logic [31:0] t, input logic [31:0] epc, input logic ev,
                       input logic [31:0] ec, input logic em, input logic [31:0] eb);
        vec_t v;
        v.rst = r; v.stall = s; v.rdy = f; v.redir = d; v.tgt = t;
        v.e_pc = epc; v.e_valid = ev; v.e_cnt = ec; v.e_mis = em; v.e_bad = eb;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic f, input logic d,
                         input logic [31:0] t);
        @(negedge clk);
        rst = r; stall = s; fetch_ready = f; redirect = d; redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] epc, input logic ev,
                             input logic [31:0] ec, input logic em, input logic [31:0] eb);
        chk({tag, ".pc"},       pc,          epc);
        chk({tag, ".pc_plus4"}, pc_plus4,    epc + 32'd4);
        chk({tag, ".valid"},    {31'b0, pc_valid}, {31'b0, ev});
        chk({tag, ".count"},    fetch_count, ec);
        chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, em});
        chk({tag, ".bad_addr"}, bad_addr,    eb);
    endtask

    // Reference model state: RUN vs HOLD is irrelevant to observable behaviour.
    logic [31:0] m_pc, m_cnt;
    logic        m_valid, m_boot;

    initial begin
        rst = 1'b1; stall = 1'b0; fetch_ready = 1'b0; redirect = 1'b0; redirect_target = '0;

        // reset, boot, sequential fetch
        add(1,0,0,0,32'h0,        32'h0,        0, 0, 0, 32'h0);
        add(1,0,1,0,32'h0,        32'h0,        0, 0, 0, 32'h0);
        add(0,0,1,1,32'h300,      32'h0,        1, 0, 0, 32'h0);
        add(0,0,1,0,32'h0,        32'h4,        1, 1, 0, 32'h0);
        add(0,0,1,0,32'h0,        32'h8,        1, 2, 0, 32'h0);
        // stall at pc=8 (imem not ready meanwhile), then release
        add(0,1,0,0,32'h0,        32'h8,        1, 2, 0, 32'h0);
        add(0,1,0,0,32'h0,        32'h8,        1, 2, 0, 32'h0);
        add(0,1,0,0,32'h0,        32'h8,        1, 2, 0, 32'h0);
        add(0,0,1,0,32'h0,        32'hC,        1, 3, 0, 32'h0);
        add(0,0,1,0,32'h0,        32'h10,       1, 4, 0, 32'h0);
        // redirect beats simultaneous stall
        add(0,1,1,1,32'h100,      32'h100,      1, 5, 0, 32'h0);
        add(0,0,1,0,32'h0,        32'h104,      1, 6, 0, 32'h0);
        // wraparound
        add(0,0,1,1,32'hFFFF_FFFC,32'hFFFF_FFFC,1, 7, 0, 32'h0);
        add(0,0,1,0,32'h0,        32'h0,        1, 8, 0, 32'h0);
        // park in HOLD at 0x40, then reset over redirect+stall
        add(0,0,0,1,32'h40,       32'h40,       1, 8, 0, 32'h0);
        add(0,0,0,0,32'h0,        32'h40,       1, 8, 0, 32'h0);
        add(1,1,1,1,32'h80,       32'h0,        0, 0, 0, 32'h0);
        add(0,0,1,1,32'h200,      32'h0,        1, 0, 0, 32'h0);
        // misaligned redirect
`ifdef PC_MISALIGN_TRAP_EN
        add(0,0,1,1,32'h102,      32'h4,        0, 1, 1, 32'h102);
        add(0,0,1,0,32'h0,        32'h8,        1, 1, 0, 32'h102);
        add(0,0,1,1,32'h105,      32'h4,        0, 2, 1, 32'h105);
        add(0,0,1,1,32'h500,      32'h8,        1, 2, 0, 32'h105);
`else
        add(0,0,1,1,32'h102,      32'h100,      1, 1, 0, 32'h0);
        add(0,0,1,0,32'h0,        32'h104,      1, 2, 0, 32'h0);
        add(0,0,1,1,32'h107,      32'h104,      1, 3, 0, 32'h0);
        add(0,0,1,0,32'h0,        32'h108,      1, 4, 0, 32'h0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].stall, vecs[i].rdy, vecs[i].redir, vecs[i].tgt);
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid,
                      vecs[i].e_cnt, vecs[i].e_mis, vecs[i].e_bad);
        end

        // randomized phase, starting from a clean reset
        apply(1, 0, 0, 0, 32'h0);
        m_pc = 32'h0; m_cnt = 0; m_valid = 1'b0; m_boot = 1'b1;
        check_all("rnd_reset", m_pc, m_valid, m_cnt, 1'b0, 32'h0);

        for (int c = 0; c < 400; c++) begin
            logic        r, s, f, d;
            logic [31:0] t;
            r = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 5) == 0);
            t = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
            t[1:0] = 2'b00;
`endif
            apply(r, s, f, d, t);
            if (r) begin
                m_pc = 32'h0; m_cnt = 0; m_valid = 1'b0; m_boot = 1'b1;
            end else if (m_boot) begin
                m_boot = 1'b0; m_valid = 1'b1;
            end else begin
                if (m_valid && f && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (d)             m_pc = {t[31:2], 2'b00};
                else if (!s && f)  m_pc = m_pc + 32'd4;
            end
            check_all($sformatf("rnd%0d", c), m_pc, m_valid, m_cnt, 1'b0, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
